// File: rtl/fetch_if.sv
// fetch_if: signal bundle between the instruction-fetch sequencer, the
// combinational instruction ROM and the decode stage.
//
// Signals:
//   imem_addr      ROM address (the sequencer's PC)
//   imem_data      ROM byte at imem_addr, valid in the same cycle
//   instr_valid    prefetch queue head is valid
//   instr_ready    decode accepts the head this cycle
//   instr_data     head opcode byte (0 when the queue is empty)
//   instr_pc       address the head byte came from (0 when the queue is empty)
//   redirect_valid branch/jump taken this cycle
//   redirect_addr  branch/jump target
//   halted         sequencer has fetched a HALT opcode
//
// Modports:
//   master  the fetch sequencer side
//   slave   the ROM / decode / branch-unit side
interface fetch_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       halted;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        input  redirect_valid,
        input  redirect_addr,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        output redirect_valid,
        output redirect_addr,
        input  halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 8-bit CPU.
// Owns the program counter, addresses the combinational instruction ROM,
// buffers fetched bytes in a DEPTH-entry prefetch queue and hands them to
// decode over a valid/ready handshake. Branch redirects flush the queue and
// reload the PC; fetching a HALT opcode stops further fetches until the next
// redirect or reset.
//
// Parameters:
//   RESET_VECTOR  PC value loaded on reset
//   DEPTH         prefetch queue entries (2 or 4)
//   HALT_OPCODE   byte value that stops fetching
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          fetch_if.master (ROM, decode and redirect signals)
//   fetch_count  (FETCH_PERF_EN only) saturating count of queue pushes
//   stall_count  (FETCH_PERF_EN only) saturating count of FETCH cycles
//                lost to a full queue with no pop
//
// Optional feature: define FETCH_PERF_EN to add the two performance counters.
module fetch_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         DEPTH        = 2,
    parameter logic [7:0] HALT_OPCODE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count,
`endif
    fetch_if.master     bus
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    // DEPTH is a power of two, so the pointers wrap on their own.
    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [0:0]       state;
    logic [7:0]       pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [15:0]      q_mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && bus.instr_ready;
    // A full queue can still take a byte when the head leaves this cycle.
    assign push  = (state == ST_FETCH) && !bus.redirect_valid && (!full || pop);

    assign bus.imem_addr   = pc;
    assign bus.instr_valid = !empty;
    assign bus.instr_data  = empty ? 8'h00 : q_mem[rd_ptr][7:0];
    assign bus.instr_pc    = empty ? 8'h00 : q_mem[rd_ptr][15:8];
    assign bus.halted      = (state == ST_HALT);

    // Queue storage: {pc, opcode} per entry, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {pc, bus.imem_data};
        end
    end

    // Control state: PC, FSM and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_VECTOR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            // Redirect discards any concurrent push/pop and a pending halt.
            state  <= ST_FETCH;
            pc     <= bus.redirect_addr;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc     <= pc + 8'd1;
                if (bus.imem_data == HALT_OPCODE) begin
                    state <= ST_HALT;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters survive redirects; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (push && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if ((state == ST_FETCH) && full && !pop && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer (DEPTH=2,
// RESET_VECTOR=0x00, HALT_OPCODE=0xFF). Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle away from the
// rising edge that updates the DUT.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] rom [256];

    int n_checks = 0;
    int n_fails  = 0;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_if bus ();

    fetch_sequencer #(
        .RESET_VECTOR (8'h00),
        .DEPTH        (2),
        .HALT_OPCODE  (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FETCH_PERF_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = rom[bus.imem_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic v, input logic [7:0] d, input logic [7:0] p);
        check({tag, "_valid"}, {15'd0, bus.instr_valid}, {15'd0, v});
        check({tag, "_data"},  {8'd0, bus.instr_data},   {8'd0, d});
        check({tag, "_pc"},    {8'd0, bus.instr_pc},     {8'd0, p});
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b1;
        bus.instr_ready = ready;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;
        rom[4] = 8'h55; rom[5] = 8'hFF;
        rom[8'h80] = 8'hA5; rom[8'hFE] = 8'hE1; rom[8'hFF] = 8'hE2;
        rom[8'h10] = 8'h3C;

        rst = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 8'h00;
        tick();
        tick();

        // ---- reset state
        check_head("rst", 1'b0, 8'h00, 8'h00);
        check("rst_addr",   {8'd0, bus.imem_addr}, 16'h0000);
        check("rst_halted", {15'd0, bus.halted},   16'h0000);

        // ---- 1: streaming, one byte per cycle
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_head($sformatf("t1_b%0d", i), 1'b1, rom[i], 8'(i));
            check($sformatf("t1_addr%0d", i), {8'd0, bus.imem_addr}, 16'(i + 1));
        end

        // ---- 2: backpressure fills the queue, then drains without loss
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_head("t2_full", 1'b1, 8'h11, 8'h00);
        check("t2_addr_hold", {8'd0, bus.imem_addr}, 16'h0002);
        bus.instr_ready = 1'b1;
        tick();
        check_head("t2_d1", 1'b1, 8'h22, 8'h01);
        tick();
        check_head("t2_d2", 1'b1, 8'h33, 8'h02);

        // ---- 3: redirect while full
        do_reset(1'b0);
        tick();
        tick();
        check("t3_full_addr", {8'd0, bus.imem_addr}, 16'h0002);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h80;
        tick();
        bus.redirect_valid = 1'b0;
        check_head("t3_flush", 1'b0, 8'h00, 8'h00);
        check("t3_addr", {8'd0, bus.imem_addr}, 16'h0080);
        tick();
        check_head("t3_target", 1'b1, 8'hA5, 8'h80);

        // ---- 4: HALT opcode at 0x05
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        check_head("t4_halt_byte", 1'b1, 8'hFF, 8'h05);
        check("t4_halted", {15'd0, bus.halted}, 16'h0001);
        check("t4_addr", {8'd0, bus.imem_addr}, 16'h0006);
        tick();
        tick();
        check_head("t4_drained", 1'b0, 8'h00, 8'h00);
        check("t4_addr_frozen", {8'd0, bus.imem_addr}, 16'h0006);
        check("t4_still_halted", {15'd0, bus.halted}, 16'h0001);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h00;
        tick();
        bus.redirect_valid = 1'b0;
        check("t4_unhalt", {15'd0, bus.halted}, 16'h0000);
        check("t4_resume_addr", {8'd0, bus.imem_addr}, 16'h0000);
        tick();
        check_head("t4_resume", 1'b1, 8'h11, 8'h00);

        // ---- 5a: PC wrap from 0xFE
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        check("t5_flush", {15'd0, bus.instr_valid}, 16'h0000);
        tick();
        check_head("t5_fe", 1'b1, 8'hE1, 8'hFE);
        tick();
        check_head("t5_ff", 1'b1, 8'hE2, 8'hFF);
        tick();
        check_head("t5_00", 1'b1, 8'h11, 8'h00);
        tick();
        check_head("t5_01", 1'b1, 8'h22, 8'h01);

        // ---- 5b: redirect beats a concurrent pop and halt-byte push
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h04;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check_head("t5b_pre", 1'b1, 8'h55, 8'h04);
        check("t5b_pre_addr", {8'd0, bus.imem_addr}, 16'h0005);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h10;
        tick();
        bus.redirect_valid = 1'b0;
        check_head("t5b_empty", 1'b0, 8'h00, 8'h00);
        check("t5b_not_halted", {15'd0, bus.halted}, 16'h0000);
        check("t5b_addr", {8'd0, bus.imem_addr}, 16'h0010);
        tick();
        check_head("t5b_target", 1'b1, 8'h3C, 8'h10);

        // ---- 6: reset mid-stream beats a redirect; perf counters
        rom[5] = 8'h66;
        tick();
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr = 8'h40;
        tick();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        check_head("t6_rst", 1'b0, 8'h00, 8'h00);
        check("t6_addr", {8'd0, bus.imem_addr}, 16'h0000);
        check("t6_halted", {15'd0, bus.halted}, 16'h0000);
`ifdef FETCH_PERF_EN
        check("t6_fetch0", fetch_count, 16'd0);
        check("t6_stall0", stall_count, 16'd0);
`endif
        for (int i = 0; i < 10; i++) tick();
        check_head("t6_after10", 1'b1, 8'h00, 8'h09);
`ifdef FETCH_PERF_EN
        check("t6_fetch10", fetch_count, 16'd10);
        check("t6_stall10", stall_count, 16'd0);
        bus.instr_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t6_fetch_stalled", fetch_count, 16'd11);
        check("t6_stall2", stall_count, 16'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
